// File: rtl/dtree_pkg.sv
// Shared types and sizes for the decision-tree feeder and its counters.
package dtree_pkg;
    localparam int NUM_FEAT  = 4;
    localparam int FEAT_W    = 8;
    localparam int CLASS_W   = 2;
    localparam int NUM_CLASS = 1 << CLASS_W;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        SETTLE  = 2'd2,
        RESULT  = 2'd3
    } feeder_state_t;
endpackage

// File: rtl/dtree_feeder_if.sv
// Byte-stream input and class-result output of the feeder, bundled as one interface.
interface dtree_feeder_if;
    import dtree_pkg::*;

    // Both channels: a transfer happens in a cycle where valid & ready are high;
    // valid is never withdrawn before that, and ready never depends on valid.
    logic               s_valid;
    logic               s_ready;
    logic [FEAT_W-1:0]  s_data;
    logic               s_last;
    logic               m_valid;
    logic               m_ready;
    logic [CLASS_W-1:0] m_class;
    logic               m_err;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class, m_err
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class, m_err
    );
endinterface

// File: rtl/class_counters.sv
// Saturating per-class hit counters with synchronous clear and readback mux.
module class_counters
    import dtree_pkg::*;
#(
    parameter int NUM_CLASS_P = NUM_CLASS,
    parameter int CLASS_W_P   = CLASS_W,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic [CLASS_W_P-1:0] inc_sel,
    input  logic                 clr,
    input  logic [CLASS_W_P-1:0] sel,
    output logic [CNT_W-1:0]     cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NUM_CLASS_P];

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASS_P; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CLASS_P; i++) cnt_q[i] <= '0;
        end else if (inc && (cnt_q[inc_sel] != CNT_MAX)) begin
            cnt_q[inc_sel] <= cnt_q[inc_sel] + CNT_W'(1);
        end
    end

    assign cnt = cnt_q[sel];
endmodule

// File: rtl/dtree_feeder.sv
// Frames a serial feature stream for the tree, waits for the slow logic to settle,
// and returns the captured class over a valid/ready port.
module dtree_feeder
    import dtree_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dtree_feeder_if.slave              bus,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_o,
    input  logic [CLASS_W-1:0]         class_i,
    input  logic [CLASS_W-1:0]         cnt_sel,
    output logic [CNT_W-1:0]           cnt_o,
    input  logic                       cnt_clr,
    output feeder_state_t              dbg_state
);
    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

    feeder_state_t              state_q, state_d;
    logic [IDX_W-1:0]           idx_q;
    logic [FEAT_W-1:0]          shadow_q [NUM_FEAT];
    logic [NUM_FEAT*FEAT_W-1:0] frame_d;
    logic [NUM_FEAT*FEAT_W-1:0] feat_q;
    logic [SET_W-1:0]           settle_q;
    logic [CLASS_W-1:0]         m_class_q;
    logic                       m_err_q;
    logic                       accept, handshake, cnt_inc;
    logic                       load_feat, enter_settle, capture, flag_err;

    assign bus.s_ready = (state_q == COLLECT) || (state_q == DRAIN);
    assign bus.m_valid = (state_q == RESULT);
    assign bus.m_class = m_class_q;
    assign bus.m_err   = m_err_q;
    assign feat_o      = feat_q;
    assign dbg_state   = state_q;

    assign accept    = bus.s_valid & bus.s_ready;
    assign handshake = bus.m_valid & bus.m_ready;
    assign cnt_inc   = handshake & ~m_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        load_feat    = 1'b0;
        enter_settle = 1'b0;
        capture      = 1'b0;
        flag_err     = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (bus.s_last) begin
                        if (idx_q == LAST_IDX) begin
                            load_feat    = 1'b1;
                            enter_settle = 1'b1;
                            state_d      = SETTLE;
                        end else begin
                            flag_err = 1'b1;
                            state_d  = RESULT;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && bus.s_last) begin
                    flag_err = 1'b1;
                    state_d  = RESULT;
                end
            end
            SETTLE: begin
                if (settle_q == SET_W'(1)) begin
                    capture = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (handshake) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // The final byte is not in the shadow yet, so splice it in on the fly.
    always_comb begin
        frame_d = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            frame_d[i*FEAT_W +: FEAT_W] = (idx_q == IDX_W'(i)) ? bus.s_data : shadow_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (state_q == COLLECT)) shadow_q[idx_q] <= bus.s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            feat_q    <= '0;
            settle_q  <= '0;
            m_class_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            if (handshake)                           idx_q <= '0;
            else if (accept && (state_q == COLLECT)) idx_q <= idx_q + IDX_W'(1);

            if (load_feat) feat_q <= frame_d;

            if (enter_settle)            settle_q <= SETTLE_LOAD;
            else if (state_q == SETTLE)  settle_q <= settle_q - SET_W'(1);

            if (capture) begin
                m_class_q <= class_i;
                m_err_q   <= 1'b0;
            end else if (flag_err) begin
                m_class_q <= '0;
                m_err_q   <= 1'b1;
            end
        end
    end

    class_counters #(
        .NUM_CLASS_P (NUM_CLASS),
        .CLASS_W_P   (CLASS_W),
        .CNT_W       (CNT_W)
    ) u_counters (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (cnt_inc),
        .inc_sel (m_class_q),
        .clr     (cnt_clr),
        .sel     (cnt_sel),
        .cnt     (cnt_o)
    );
endmodule

// File: tb/tb_dtree_feeder.sv
// Randomised scoreboard bench for dtree_feeder with a behavioural tree and counter model.
module tb_dtree_feeder;
    import dtree_pkg::*;

    localparam int SETTLE  = 2;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_FEAT*FEAT_W-1:0] feat_o;
    logic [CLASS_W-1:0]         class_i;
    logic [CLASS_W-1:0]         cnt_sel;
    logic [CNT_W-1:0]           cnt_o;
    logic                       cnt_clr;
    feeder_state_t              dbg_state;

    dtree_feeder_if bus ();

    dtree_feeder #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .feat_o    (feat_o),
        .class_i   (class_i),
        .cnt_sel   (cnt_sel),
        .cnt_o     (cnt_o),
        .cnt_clr   (cnt_clr),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Stand-in for the combinational tree.
    function automatic logic [1:0] tree_fn(input logic [31:0] f);
        if (f[7:0] >= 8'h80) return f[8] ? 2'd3 : 2'd1;
        return (f[31:24] >= 8'h40) ? 2'd2 : 2'd0;
    endfunction

    assign class_i = tree_fn(feat_o);

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [34:0] exp_q [$];           // {err, class, feat_o}
    int          ref_cnt [4];
    logic [31:0] model_feat = '0;
    logic [7:0]  fb [16];
    int          flen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [34:0] e;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ref_cnt[i] = 0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {29'd0, bus.m_err, bus.m_class, feat_o}, {29'd0, e});
                    if (!e[34] && !cnt_clr && ref_cnt[e[33:32]] < CNT_MAX)
                        ref_cnt[e[33:32]]++;
                end
            end
            if (cnt_clr) for (int i = 0; i < 4; i++) ref_cnt[i] = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic l, output int waits);
        logic acc;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        bus.s_last  = l;
        waits = 0;
        do begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk); #1;
            if (!acc) waits++;
        end while (!acc && waits < 100);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame_bytes(output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < flen; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            send_byte(fb[i], (i == flen - 1), w);
            stalls += w;
        end
    endtask

    task automatic run_frame(input int hold, input bit clr_hs);
        logic [31:0] feat;
        logic [1:0]  cls;
        logic        err;
        int          lat, k, stalls;
        err = (flen != NUM_FEAT);
        if (!err) begin
            feat       = {fb[3], fb[2], fb[1], fb[0]};
            cls        = tree_fn(feat);
            model_feat = feat;
            lat        = SETTLE;
        end else begin
            feat = model_feat;
            cls  = 2'd0;
            lat  = 0;
        end
        exp_q.push_back({err, cls, model_feat});
        bus.m_ready = (hold == 0);
        send_frame_bytes(stalls);
        check("s_ready_stall", stalls, 0);
        @(negedge clk);
        if (!err) check("feat_o_next_cycle", feat_o, feat);
        k = 0;
        while (!bus.m_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("result_latency", k, lat);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                bus.s_valid = 1'b1;
                bus.s_data  = 8'($urandom_range(0, 255));
                bus.s_last  = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("hold", {bus.m_valid, bus.s_ready, bus.m_class, bus.m_err}, {1'b1, 1'b0, cls, err});
            end
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            bus.m_ready = 1'b1;
            cnt_clr     = clr_hs;
            @(negedge clk);
        end
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("post_handshake", {bus.m_valid, bus.s_ready}, 2'b01);
        @(posedge clk); #1;
    endtask

    task automatic check_counters();
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            @(negedge clk);
            check($sformatf("counter%0d", s), cnt_o, ref_cnt[s]);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_frame4(input logic [7:0] b0, b1, b2, b3);
        flen = 4;
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int stalls;
        int hold;
        bit saw;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        cnt_clr = 1'b0;
        cnt_sel = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.m_valid, bus.s_ready, bus.m_class, bus.m_err}, 5'b01000);
        check("reset_feat", feat_o, 0);
        check("reset_state", dbg_state, COLLECT);
        check_counters();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed good frame: class 2, feat 0x40302010
        set_frame4(8'h10, 8'h20, 8'h30, 8'h40);
        run_frame(0, 1'b0);
        check_counters();

        // Short frame
        flen = 2; fb[0] = 8'hAA; fb[1] = 8'hBB;
        run_frame(0, 1'b0);
        check_counters();

        // Long frame followed by a good frame
        flen = 6;
        for (int i = 0; i < 6; i++) fb[i] = 8'(8'h90 + i);
        run_frame(0, 1'b0);
        set_frame4(8'h85, 8'h00, 8'h11, 8'h22);
        run_frame(0, 1'b0);
        check_counters();

        // Backpressure for 10 cycles
        set_frame4(8'h01, 8'h02, 8'h03, 8'h50);
        run_frame(10, 1'b0);
        check_counters();

        // Saturation at 2^CNT_W-1
        pulse_clr();
        for (int n = 0; n < 9; n++) begin
            set_frame4(8'h90, 8'h01, 8'(n), 8'h00);
            run_frame(0, 1'b0);
        end
        check_counters();

        // Clear coincident with increment
        set_frame4(8'h90, 8'h01, 8'h00, 8'h00);
        run_frame(2, 1'b1);
        check_counters();

        // Randomised frames
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0:       flen = $urandom_range(1, 3);
                1:       flen = $urandom_range(5, 8);
                default: flen = 4;
            endcase
            for (int i = 0; i < flen; i++) fb[i] = 8'($urandom_range(0, 255));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_frame(hold, (hold > 0) && ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 15) == 0) pulse_clr();
            if (n % 10 == 9) check_counters();
        end

        // Reset in the middle of SETTLE
        bus.m_ready = 1'b1;
        set_frame4(8'h12, 8'h34, 8'h56, 8'h78);
        send_frame_bytes(stalls);
        check("settle_state", dbg_state, SETTLE);
        rst_n = 1'b0;
        #1;
        check("midsettle_reset_outputs", {bus.m_valid, bus.s_ready, bus.m_class, bus.m_err}, 5'b01000);
        check("midsettle_reset_feat", feat_o, 0);
        model_feat = '0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.m_valid) saw = 1'b1;
        end
        check("no_result_after_reset", saw, 0);
        @(posedge clk); #1;
        check_counters();

        // Recovery after reset
        set_frame4(8'h80, 8'h00, 8'h00, 8'h00);
        run_frame(0, 1'b0);
        check_counters();

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
